// File: rtl/key_ctrl_pkg.sv
// Shared definitions for the set-mode key controller: state encoding,
// default key polarity, counter width and calendar field indices.
package key_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SET  = 1'b1
    } state_t;

    localparam logic KEY_ACTIVE_DEF = 1'b0;

    localparam int CNT_W = 32;

    localparam logic [2:0] FLD_SEC   = 3'd0;
    localparam logic [2:0] FLD_MIN   = 3'd1;
    localparam logic [2:0] FLD_HOUR  = 3'd2;
    localparam logic [2:0] FLD_DAY   = 3'd3;
    localparam logic [2:0] FLD_MONTH = 3'd4;
    localparam logic [2:0] FLD_YEAR  = 3'd5;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/key_edge_det.sv
// Press detector for one debounced key. A key must be seen released once
// after reset before any press is reported, so a key stuck at the pressed
// level (or the debouncer's reset value) never produces an event.
module key_edge_det
    import key_ctrl_pkg::*;
#(
    parameter logic KEY_ACTIVE = KEY_ACTIVE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic press
);

    logic prev;
    logic armed;

    // Track the previous level and arm on the first released sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= KEY_ACTIVE;
            armed <= 1'b0;
        end else begin
            prev <= level;
            if (level != KEY_ACTIVE) begin
                armed <= 1'b1;
            end
        end
    end

    // Press is combinational so the controller registers its reaction on
    // the same edge that samples the new level.
    assign press = armed && (level == KEY_ACTIVE) && (prev != KEY_ACTIVE);

endmodule

// File: rtl/key_set_ctrl.sv
// Set-mode controller for the clock-calendar. Turns MODE/SEL/UP presses
// into set-mode entry/exit, field selection and increment requests with
// long-press auto-repeat, and aborts an edit after an idle timeout.
module key_set_ctrl
    import key_ctrl_pkg::*;
#(
    parameter logic KEY_ACTIVE  = KEY_ACTIVE_DEF,
    parameter int   LONG_TIME   = 50_000_000,
    parameter int   REPEAT_TIME = 10_000_000,
    parameter int   TIMEOUT     = 500_000_000,
    parameter int   NUM_FIELDS  = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_sel,
    input  logic       key_up,
    output logic       set_mode,
    output logic [2:0] field_sel,
    output logic       inc_pulse,
    output logic       save_pulse,
    output logic       abort_pulse
);

    localparam logic [CNT_W-1:0] LONG_C    = CNT_W'(LONG_TIME);
    localparam logic [CNT_W-1:0] REPEAT_C  = CNT_W'(REPEAT_TIME);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       FLD_LAST  = 3'(NUM_FIELDS - 1);

    logic mode_press;
    logic sel_press;
    logic up_press;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] idle_cnt;
    logic             holding;
    logic             repeating;

    logic up_lvl;
    logic hold_fire;
    logic timeout;

    key_edge_det #(.KEY_ACTIVE(KEY_ACTIVE)) u_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .level (key_mode),
        .press (mode_press)
    );

    key_edge_det #(.KEY_ACTIVE(KEY_ACTIVE)) u_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .level (key_sel),
        .press (sel_press)
    );

    key_edge_det #(.KEY_ACTIVE(KEY_ACTIVE)) u_up (
        .clk   (clk),
        .rst_n (rst_n),
        .level (key_up),
        .press (up_press)
    );

    // Decode the repeat instant and the idle timeout from the counters.
    // hold_cnt holds the cycles elapsed since the last increment slot, so
    // the first slot after the press is LONG_TIME away and later ones are
    // REPEAT_TIME apart.
    always_comb begin
        up_lvl    = (key_up == KEY_ACTIVE);
        hold_fire = 1'b0;
        if (holding && up_lvl) begin
            hold_fire = repeating ? (hold_cnt == REPEAT_C) : (hold_cnt == LONG_C);
        end
        timeout = (idle_cnt == IDLE_LAST);
    end

    // Set-mode FSM with hold/repeat and idle counters; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            set_mode    <= 1'b0;
            field_sel   <= FLD_SEC;
            inc_pulse   <= 1'b0;
            save_pulse  <= 1'b0;
            abort_pulse <= 1'b0;
            hold_cnt    <= '0;
            idle_cnt    <= '0;
            holding     <= 1'b0;
            repeating   <= 1'b0;
        end else begin
            inc_pulse   <= 1'b0;
            save_pulse  <= 1'b0;
            abort_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    holding   <= 1'b0;
                    repeating <= 1'b0;
                    hold_cnt  <= '0;
                    if (mode_press) begin
                        state     <= ST_SET;
                        set_mode  <= 1'b1;
                        field_sel <= FLD_SEC;
                        idle_cnt  <= '0;
                    end
                end
                ST_SET: begin
                    if (mode_press || timeout) begin
                        // MODE commits, otherwise the idle timeout discards.
                        state       <= ST_IDLE;
                        set_mode    <= 1'b0;
                        field_sel   <= FLD_SEC;
                        save_pulse  <= mode_press;
                        abort_pulse <= !mode_press;
                        holding     <= 1'b0;
                        repeating   <= 1'b0;
                        hold_cnt    <= '0;
                        idle_cnt    <= '0;
                    end else begin
                        // Hold tracking keeps running even when SEL wins the
                        // cycle, so a repeat continues on the new field.
                        if (!up_lvl) begin
                            holding   <= 1'b0;
                            repeating <= 1'b0;
                            hold_cnt  <= '0;
                        end else if (up_press) begin
                            holding   <= 1'b1;
                            repeating <= 1'b0;
                            hold_cnt  <= CNT_ONE;
                        end else if (holding) begin
                            if (hold_fire) begin
                                repeating <= 1'b1;
                                hold_cnt  <= CNT_ONE;
                            end else begin
                                hold_cnt <= sat_inc(hold_cnt);
                            end
                        end

                        if (sel_press) begin
                            field_sel <= (field_sel == FLD_LAST) ? FLD_SEC : field_sel + 3'd1;
                        end else if (up_press || hold_fire) begin
                            inc_pulse <= 1'b1;
                        end

                        if (sel_press || up_press || up_lvl) begin
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= sat_inc(idle_cnt);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_set_ctrl.sv
// Self-checking bench for key_set_ctrl with a cycle-level behavioural model
// expressed in terms of event times (press cycle, last activity cycle).
module tb_key_set_ctrl;

    localparam int L  = 10;
    localparam int R  = 4;
    localparam int TO = 50;
    localparam int NF = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_sel = 1'b0;
    logic       key_up = 1'b0;
    logic       set_mode;
    logic [2:0] field_sel;
    logic       inc_pulse;
    logic       save_pulse;
    logic       abort_pulse;

    int checks = 0;
    int errors = 0;

    key_set_ctrl #(
        .KEY_ACTIVE  (1'b0),
        .LONG_TIME   (L),
        .REPEAT_TIME (R),
        .TIMEOUT     (TO),
        .NUM_FIELDS  (NF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_mode    (key_mode),
        .key_sel     (key_sel),
        .key_up      (key_up),
        .set_mode    (set_mode),
        .field_sel   (field_sel),
        .inc_pulse   (inc_pulse),
        .save_pulse  (save_pulse),
        .abort_pulse (abort_pulse)
    );

    always #5 clk = ~clk;

    // Reference model state
    int cyc = 0;
    bit m_set = 0;
    int m_field = 0;
    bit m_inc = 0, m_save = 0, m_abort = 0;
    bit m_prev[3];
    bit m_armed[3];
    int m_last = 0;
    bit m_hold = 0;
    int m_hold_t = 0;

    task automatic model_reset();
        m_set = 0; m_field = 0; m_inc = 0; m_save = 0; m_abort = 0; m_hold = 0;
        for (int i = 0; i < 3; i++) begin
            m_prev[i] = 1'b0;
            m_armed[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit lv[3];
        bit pr[3];
        bit up_held;
        bit rep;
        int age;
        lv[0] = key_mode; lv[1] = key_sel; lv[2] = key_up;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            pr[i] = (lv[i] == 1'b0) && (m_prev[i] == 1'b1) && m_armed[i];
            if (lv[i]) m_armed[i] = 1'b1;
            m_prev[i] = lv[i];
        end
        m_inc = 0; m_save = 0; m_abort = 0;
        up_held = (key_up == 1'b0);
        rep = 0;
        if (!m_set) begin
            if (pr[0]) begin
                m_set = 1; m_field = 0; m_last = cyc; m_hold = 0;
            end
        end else if (pr[0]) begin
            m_save = 1; m_set = 0; m_field = 0; m_hold = 0;
        end else if (cyc - m_last == TO) begin
            m_abort = 1; m_set = 0; m_field = 0; m_hold = 0;
        end else begin
            if (!up_held) begin
                m_hold = 0;
            end else if (m_hold) begin
                age = cyc - m_hold_t;
                rep = (age == L) || (age > L && ((age - L) % R) == 0);
            end
            if (pr[2]) begin
                m_hold = 1; m_hold_t = cyc;
            end
            if (pr[1]) m_field = (m_field + 1) % NF;
            else if (pr[2] || rep) m_inc = 1;
            if (pr[1] || pr[2] || up_held) m_last = cyc;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    function automatic logic [6:0] dut_vec();
        return {set_mode, field_sel, inc_pulse, save_pulse, abort_pulse};
    endfunction

    function automatic logic [6:0] mdl_vec();
        return {m_set, 3'(m_field), m_inc, m_save, m_abort};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_mode = 1'b0; key_sel = 1'b0; key_up = 1'b0;
        #12;
        checks++;
        if (dut_vec() !== 7'b0) begin
            errors++; $display("FAIL reset_state got=%b want=%b", dut_vec(), 7'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL reset_model cyc=%0d got=%b want=%b", cyc, dut_vec(), mdl_vec());
            end
            checks++;
            if ({set_mode, inc_pulse, save_pulse, abort_pulse} !== 4'b0) begin
                errors++; $display("FAIL unarmed_keys cyc=%0d got=%b want=0000", cyc, {set_mode, inc_pulse, save_pulse, abort_pulse});
            end
        end
        key_mode = 1'b1; key_sel = 1'b1; key_up = 1'b1;
        tick();
        tick();
        key_mode = 1'b0;
        tick();
        checks++;
        if ({set_mode, field_sel} !== 4'b1000) begin
            errors++; $display("FAIL enter_set got=%b want=1000", {set_mode, field_sel});
        end
        key_mode = 1'b1;
        tick();
    endtask

    task automatic test_field_sel();
        int exp_f[7] = '{1, 2, 3, 4, 5, 0, 1};
        for (int i = 0; i < 7; i++) begin
            key_sel = 1'b0;
            tick();
            checks++;
            if (field_sel !== 3'(exp_f[i]) || inc_pulse !== 1'b0) begin
                errors++; $display("FAIL field_step%0d got=%0d/%b want=%0d/0", i, field_sel, inc_pulse, exp_f[i]);
            end
            key_sel = 1'b1;
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL field_model cyc=%0d got=%b want=%b", cyc, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_up_repeat();
        int got[$];
        int exp_t[5] = '{0, 10, 14, 18, 22};
        int p;
        key_up = 1'b0;
        tick();
        p = cyc;
        if (inc_pulse) got.push_back(0);
        for (int k = 1; k < 35; k++) begin
            if (k == 25) key_up = 1'b1;
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL repeat_model cyc=%0d got=%b want=%b", cyc, dut_vec(), mdl_vec());
            end
            if (inc_pulse) got.push_back(cyc - p);
        end
        checks++;
        if (got.size() != 5) begin
            errors++; $display("FAIL repeat_count got=%0d want=5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] != exp_t[i]) begin
                    errors++; $display("FAIL repeat_time%0d got=P+%0d want=P+%0d", i, got[i], exp_t[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int s;
        int found;
        int extra;
        int saves;
        key_mode = 1'b0;
        tick();
        checks++;
        if (save_pulse !== 1'b1 || set_mode !== 1'b0) begin
            errors++; $display("FAIL exit_save got=%b%b want=10", save_pulse, set_mode);
        end
        key_mode = 1'b1;
        tick();
        key_mode = 1'b0;
        tick();
        key_mode = 1'b1;
        key_sel = 1'b0;
        tick();
        s = cyc;
        key_sel = 1'b1;
        found = -1; extra = 0; saves = 0;
        for (int k = 0; k < 70; k++) begin
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL timeout_model cyc=%0d got=%b want=%b", cyc, dut_vec(), mdl_vec());
            end
            if (save_pulse) saves++;
            if (abort_pulse) begin
                if (found < 0) found = cyc - s;
                else extra++;
                checks++;
                if ({set_mode, field_sel} !== 4'b0) begin
                    errors++; $display("FAIL abort_outputs got=%b want=0000", {set_mode, field_sel});
                end
            end
        end
        checks++;
        if (found != TO) begin
            errors++; $display("FAIL abort_time got=%0d want=%0d", found, TO);
        end
        checks++;
        if (extra != 0 || saves != 0) begin
            errors++; $display("FAIL abort_extra got=%0d/%0d want=0/0", extra, saves);
        end
    endtask

    task automatic test_mode_up_same();
        key_mode = 1'b0; tick(); key_mode = 1'b1; tick();
        key_sel = 1'b0; tick(); key_sel = 1'b1; tick();
        checks++;
        if ({set_mode, field_sel} !== 4'b1001) begin
            errors++; $display("FAIL pre_collide got=%b want=1001", {set_mode, field_sel});
        end
        key_mode = 1'b0; key_up = 1'b0;
        tick();
        checks++;
        if ({save_pulse, inc_pulse, set_mode, field_sel} !== 6'b100000) begin
            errors++; $display("FAIL mode_up_collide got=%b want=100000", {save_pulse, inc_pulse, set_mode, field_sel});
        end
        key_mode = 1'b1; key_up = 1'b1;
        tick();
        checks++;
        if (dut_vec() !== mdl_vec()) begin
            errors++; $display("FAIL collide_model got=%b want=%b", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_reset_mid();
        key_mode = 1'b0; tick(); key_mode = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin
            key_sel = 1'b0; tick(); key_sel = 1'b1; tick();
        end
        key_up = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        checks++;
        if ({set_mode, field_sel} !== 4'b1011) begin
            errors++; $display("FAIL pre_reset got=%b want=1011", {set_mode, field_sel});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 7'b0) begin
            errors++; $display("FAIL async_reset got=%b want=%b", dut_vec(), 7'b0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if ({inc_pulse, save_pulse, abort_pulse, set_mode} !== 4'b0) begin
                errors++; $display("FAIL post_reset_held cyc=%0d got=%b want=0000", cyc, {inc_pulse, save_pulse, abort_pulse, set_mode});
            end
        end
        key_up = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int n_inc;
        n_inc = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) < 2) key_mode = ~key_mode;
            if ($urandom_range(0, 99) < 10) key_sel = ~key_sel;
            if ($urandom_range(0, 99) < 5) key_up = ~key_up;
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL random_model cyc=%0d got=%b want=%b", cyc, dut_vec(), mdl_vec());
            end
            checks++;
            if (save_pulse && abort_pulse) begin
                errors++; $display("FAIL save_abort_both cyc=%0d got=11 want=not both", cyc);
            end
            if (inc_pulse) n_inc++;
        end
        checks++;
        if (n_inc == 0) begin
            errors++; $display("FAIL random_activity got=%0d increments want=nonzero", n_inc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_field_sel();
        test_up_repeat();
        test_timeout();
        test_mode_up_same();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_set_ctrl.md
Name: key_set_ctrl

Overview:
- Time/date set-mode controller for the clock-calendar.
- Consumes the debounced level outputs of three key debouncers: MODE, SEL, UP.
- Turns them into set-mode sequencing for the display/counter datapath: enter/exit set mode, select the field being edited, and issue increment pulses with long-press auto-repeat.
- Sits between the key debouncers and the calendar counter/display blocks. It is the only consumer of the debounced key levels.

Parameters:
- KEY_ACTIVE, 1'b0: debounced level meaning "pressed". Keys are active-low.
- LONG_TIME, 50_000_000: cycles UP must be held before auto-repeat starts (1 s at 50 MHz).
- REPEAT_TIME, 10_000_000: cycles between auto-repeat increments (200 ms).
- TIMEOUT, 500_000_000: idle cycles in SET before aborting without save (10 s).
- NUM_FIELDS, 6: number of editable fields (sec, min, hour, day, month, year). Allowed range 2..8.

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst_n, input, 1: asynchronous active-low reset.
- key_mode, input, 1: debounced MODE level.
- key_sel, input, 1: debounced SEL level.
- key_up, input, 1: debounced UP level.
- set_mode, output, 1: high while in SET state. Registered.
- field_sel, output, 3: index of the field being edited; 0 = sec. Registered.
- inc_pulse, output, 1: one-cycle increment request for field_sel. Registered.
- save_pulse, output, 1: one-cycle "commit edited time". Registered.
- abort_pulse, output, 1: one-cycle "discard edits, timeout". Registered.

Behaviour:
- Reset (async, rst_n low): state=IDLE, set_mode=0, field_sel=0, all pulses 0, counters 0, every key disarmed.
- Arming:
  - The debouncer output resets to 0, which equals the pressed level.
  - A key is armed only after one released sample (level != KEY_ACTIVE) is seen.
  - No press event is generated before the key is armed, so a held or reset-valued key never produces a spurious event.
- Press event:
  - Condition: level == KEY_ACTIVE on this clk edge, previous registered level != KEY_ACTIVE, and key armed.
  - Inputs come from the debouncer and are already synchronous; there is no extra synchroniser.
  - All outputs react at the same edge that samples the press. Latency is 1 cycle from the input change.
- State IDLE:
  - MODE press -> SET, set_mode=1, field_sel=0, idle counter cleared.
  - SEL and UP are ignored.
- State SET:
  - MODE press -> save_pulse=1 for 1 cycle, then IDLE, set_mode=0, field_sel=0.
  - SEL press -> field_sel <= field_sel+1, wrapping NUM_FIELDS-1 -> 0.
  - UP press -> inc_pulse=1 at the press cycle P; hold counter starts.
  - UP held continuously -> further inc_pulse at P+LONG_TIME, then every REPEAT_TIME cycles after that.
  - UP release stops repeat immediately and clears the hold counter.
  - Idle counter increments each cycle.
  - Idle counter clears on any press event and on every cycle UP is held.
  - Idle counter reaching TIMEOUT-1 -> abort_pulse=1 for 1 cycle, then IDLE, set_mode=0, field_sel=0.
- Simultaneous events in one cycle, priority: MODE press > timeout > SEL press > UP press/repeat.
  - A lower-priority event in the same cycle is dropped, not deferred.
  - SEL and UP together: field_sel advances and no inc_pulse is issued. A repeat continuing on the new field is allowed.
- UP held across entry to SET: no increment until it is released and pressed again, because a press requires a level edge.
- Pulses never last more than 1 cycle. save_pulse and abort_pulse are mutually exclusive.
- Counters:
  - Hold and idle counters are 32 bit.
  - Compare with ==, never >=. Saturate at terminal value, never wrap.
- Reset asserted mid-edit: immediate return to IDLE, no save_pulse, no abort_pulse.

Decomposition:
- Package key_ctrl_pkg holds:
  - state encodings ST_IDLE and ST_SET;
  - the KEY_ACTIVE default;
  - counter width CNT_W=32;
  - field index constants FLD_SEC..FLD_YEAR.
- One sub-module, key_edge_det, instantiated 3 times.
  - Ports: clk, rst_n, level, press.
  - Holds the previous-level register and the arm flag; outputs a 1-cycle press.
- The FSM, hold/repeat counter and idle counter live in key_set_ctrl.

Test Plan:
All scenarios use LONG_TIME=10, REPEAT_TIME=4, TIMEOUT=50, NUM_FIELDS=6.
1. Release reset with all keys at 0 (pressed level) for 20 cycles -> no pulses, set_mode=0. Keys go to 1, then MODE goes to 0 -> set_mode=1 one cycle later, field_sel=0.
2. In SET, 7 SEL presses -> field_sel steps 1,2,3,4,5,0,1. No inc_pulse.
3. In SET, UP pressed at cycle P and held 25 cycles -> inc_pulse exactly at P, P+10, P+14, P+18, P+22. Release -> no further pulses.
4. Enter SET, no keys for 50 cycles -> abort_pulse for 1 cycle at idle count 49, then set_mode=0, field_sel=0, no save_pulse.
5. MODE and UP pressed in the same cycle while in SET -> save_pulse=1, inc_pulse=0, state IDLE.
6. rst_n driven low mid-repeat with field_sel=3 -> all outputs 0 asynchronously. After release, UP still held -> no inc_pulse.
